// File: rtl/fft16_bfly_scheduler.sv
// fft16_bfly_scheduler: 16-point in-place radix-2 DIT FFT sequencer driving an external butterfly
module fft16_bfly_scheduler #(
   parameter int WORD_SIZE = 16,
   parameter int FRACTION  = 8
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_valid,
   input  logic signed [WORD_SIZE-1:0] i_re,
   input  logic signed [WORD_SIZE-1:0] i_im,
   output logic                        o_ready,
   output logic signed [WORD_SIZE-1:0] o_in0_re,
   output logic signed [WORD_SIZE-1:0] o_in0_im,
   output logic signed [WORD_SIZE-1:0] o_in1_re,
   output logic signed [WORD_SIZE-1:0] o_in1_im,
   output logic signed [WORD_SIZE-1:0] o_twiddle_re,
   output logic signed [WORD_SIZE-1:0] o_twiddle_im,
   output logic                        o_bfly_start,
   input  logic signed [WORD_SIZE-1:0] i_out0_re,
   input  logic signed [WORD_SIZE-1:0] i_out0_im,
   input  logic signed [WORD_SIZE-1:0] i_out1_re,
   input  logic signed [WORD_SIZE-1:0] i_out1_im,
   input  logic                        i_butterfly_done,
   output logic                        o_valid,
   output logic signed [WORD_SIZE-1:0] o_re,
   output logic signed [WORD_SIZE-1:0] o_im,
   output logic [3:0]                  o_index,
   input  logic                        i_out_ready,
   output logic                        o_fft_done
);
   localparam int TW_RE [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   localparam int TW_IM [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
   localparam int SCALE = 1 << FRACTION;
   typedef enum logic [2:0] {LOAD, ISSUE, WAIT, WRITE, UNLOAD} state_t;
   state_t state;
   logic signed [WORD_SIZE-1:0] mem_re [16];
   logic signed [WORD_SIZE-1:0] mem_im [16];
   logic [3:0] n, k, top, bot, n_rev;
   logic [1:0] s;
   logic [2:0] b, tw_k;
   logic done_q;
   int hh;
   assign n_rev = {n[0], n[1], n[2], n[3]};
   assign o_ready = state == LOAD;
   assign o_fft_done = !i_rst && state == UNLOAD && o_valid && i_out_ready && o_index == 4'd15;
   // butterfly pair addresses and twiddle index for stage s, butterfly b
   always_comb begin
      hh = 1 << s;
      top = 4'((int'(b) >> s) * 2 * hh + (int'(b) & (hh - 1)));
      bot = top + 4'(hh);
      tw_k = 3'((int'(b) & (hh - 1)) * (8 >> s));
   end
   // sample storage in bit-reversed order and in-place butterfly write-back; never cleared
   always_ff @(posedge i_clk) begin
      if (!i_rst && state == LOAD && i_valid) begin
         mem_re[n_rev] <= i_re;
         mem_im[n_rev] <= i_im;
      end else if (!i_rst && state == WRITE) begin
         mem_re[top] <= i_out0_re;
         mem_im[top] <= i_out0_im;
         mem_re[bot] <= i_out1_re;
         mem_im[bot] <= i_out1_im;
      end
   end
   // sequencer: load, 32 butterflies over 4 stages, then handshaked unload in natural order
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= LOAD;
         n <= '0;
         s <= '0;
         b <= '0;
         k <= '0;
         done_q <= 1'b0;
         o_bfly_start <= 1'b0;
         o_valid <= 1'b0;
         o_index <= '0;
         o_re <= '0;
         o_im <= '0;
         o_in0_re <= '0;
         o_in0_im <= '0;
         o_in1_re <= '0;
         o_in1_im <= '0;
         o_twiddle_re <= '0;
         o_twiddle_im <= '0;
      end else begin
         done_q <= i_butterfly_done;
         o_bfly_start <= 1'b0;
         case (state)
            LOAD: if (i_valid) begin
               n <= n + 4'd1;
               if (n == 4'd15) begin
                  state <= ISSUE;
                  s <= '0;
                  b <= '0;
               end
            end
            ISSUE: begin
               o_in0_re <= mem_re[top];
               o_in0_im <= mem_im[top];
               o_in1_re <= mem_re[bot];
               o_in1_im <= mem_im[bot];
               o_twiddle_re <= WORD_SIZE'(TW_RE[tw_k] * SCALE / 256);
               o_twiddle_im <= WORD_SIZE'(TW_IM[tw_k] * SCALE / 256);
               o_bfly_start <= 1'b1;
               state <= WAIT;
            end
            WAIT: if (i_butterfly_done && !done_q) state <= WRITE;
            WRITE: begin
               b <= b + 3'd1;
               k <= '0;
               if (b == 3'd7) s <= s + 2'd1;
               state <= (b == 3'd7 && s == 2'd3) ? UNLOAD : ISSUE;
            end
            UNLOAD: if (!o_valid) begin
               o_valid <= 1'b1;
               o_index <= k;
               o_re <= mem_re[k];
               o_im <= mem_im[k];
            end else if (i_out_ready) begin
               if (k == 4'd15) begin
                  o_valid <= 1'b0;
                  state <= LOAD;
                  n <= '0;
                  k <= '0;
               end else begin
                  k <= k + 4'd1;
                  o_index <= k + 4'd1;
                  o_re <= mem_re[k + 4'd1];
                  o_im <= mem_im[k + 4'd1];
               end
            end
            default: state <= LOAD;
         endcase
      end
   end
endmodule

// File: tb/tb_fft16_bfly_scheduler.sv
// tb_fft16_bfly_scheduler: scoreboard bench with a behavioural butterfly and a reference FFT model
module tb_fft16_bfly_scheduler;
   logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
   logic signed [15:0] in_re = 0, in_im = 0;
   logic signed [15:0] bf0_re = 0, bf0_im = 0, bf1_re = 0, bf1_im = 0;
   logic bf_done = 0, extra_done = 0, done;
   logic signed [15:0] in0_re, in0_im, in1_re, in1_im, tw_re_o, tw_im_o, o_re, o_im;
   logic ready, bfly_start, o_valid, fft_done;
   logic [3:0] o_index;
   int total = 0, bad = 0, starts = 0, fft_dones = 0, hold_len = 1, dly = 0, hl = 0;
   int xr [16], xi [16], cr [16], ci [16];
   int tw_re [8] = '{256, 237, 181, 98, 0, -98, -181, -237};
   int tw_im [8] = '{0, -98, -181, -237, -256, -237, -181, -98};
   logic [95:0] op_q [$];
   logic [35:0] bin_q [$];
   logic [95:0] first_ops [2];
   assign done = bf_done | extra_done;

   fft16_bfly_scheduler dut (
      .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .i_re(in_re), .i_im(in_im),
      .o_ready(ready), .o_in0_re(in0_re), .o_in0_im(in0_im), .o_in1_re(in1_re), .o_in1_im(in1_im),
      .o_twiddle_re(tw_re_o), .o_twiddle_im(tw_im_o), .o_bfly_start(bfly_start),
      .i_out0_re(bf0_re), .i_out0_im(bf0_im), .i_out1_re(bf1_re), .i_out1_im(bf1_im),
      .i_butterfly_done(done), .o_valid(o_valid), .o_re(o_re), .o_im(o_im), .o_index(o_index),
      .i_out_ready(out_ready), .o_fft_done(fft_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int s16(input int x);
      logic signed [15:0] v;
      v = x[15:0];
      return int'(v);
   endfunction

   function automatic void bfly(input int ar, ai, br, bi, wr, wi, output int o0r, o0i, o1r, o1i);
      int pr, pi;
      pr = (br * wr - bi * wi) >>> 8;
      pi = (br * wi + bi * wr) >>> 8;
      o0r = s16(ar + pr);
      o0i = s16(ai + pi);
      o1r = s16(ar - pr);
      o1i = s16(ai - pi);
   endfunction

   // behavioural butterfly: result ready 3 cycles after start, done held hold_len cycles
   always @(negedge clk) begin : bf
      int r0, i0, r1, i1;
      if (hl > 0) begin
         hl--;
         if (hl == 0) bf_done = 0;
      end
      if (bfly_start) begin
         bfly(in0_re, in0_im, in1_re, in1_im, tw_re_o, tw_im_o, r0, i0, r1, i1);
         bf0_re = 16'(r0); bf0_im = 16'(i0); bf1_re = 16'(r1); bf1_im = 16'(i1);
         dly = 3;
      end else if (dly > 0) begin
         dly--;
         if (dly == 0) begin
            bf_done = 1;
            hl = hold_len;
         end
      end
   end

   // scoreboard monitor: operands on every start, bins on every valid cycle
   always @(negedge clk) begin : mon
      if (bfly_start) begin
         starts++;
         if (starts <= 2) first_ops[starts-1] = {in0_re, in0_im, in1_re, in1_im, tw_re_o, tw_im_o};
         if (op_q.size() == 0) check("op_extra", 1, 0);
         else check("op", {in0_re, in0_im, in1_re, in1_im, tw_re_o, tw_im_o}, op_q.pop_front());
      end
      if (o_valid) begin
         if (bin_q.size() == 0) check("bin_extra", 1, 0);
         else begin
            check("bin", {o_index, o_re, o_im}, bin_q[0]);
            if (out_ready) begin
               check("fft_done", fft_done, bin_q[0][35:32] == 4'd15);
               void'(bin_q.pop_front());
            end
         end
      end
      if (fft_done) fft_dones++;
   end

   task automatic model_frame(input bit const_bins);
      int mr [16], mi [16];
      int r, h, t, u, kk, o0r, o0i, o1r, o1i;
      for (int n = 0; n < 16; n++) begin
         r = 0;
         for (int i = 0; i < 4; i++) r |= ((n >> i) & 1) << (3 - i);
         mr[r] = xr[n];
         mi[r] = xi[n];
      end
      for (int s = 0; s < 4; s++) begin
         h = 1 << s;
         for (int g = 0; g < 16; g += 2 * h)
            for (int j = 0; j < h; j++) begin
               t = g + j;
               u = t + h;
               kk = j * (8 >> s);
               op_q.push_back({16'(mr[t]), 16'(mi[t]), 16'(mr[u]), 16'(mi[u]), 16'(tw_re[kk]), 16'(tw_im[kk])});
               bfly(mr[t], mi[t], mr[u], mi[u], tw_re[kk], tw_im[kk], o0r, o0i, o1r, o1i);
               mr[t] = o0r; mi[t] = o0i; mr[u] = o1r; mi[u] = o1i;
            end
      end
      for (int k = 0; k < 16; k++)
         bin_q.push_back(const_bins ? {4'(k), 16'(cr[k]), 16'(ci[k])} : {4'(k), 16'(mr[k]), 16'(mi[k])});
   endtask

   task automatic load_samples(input bit junk);
      for (int n = 0; n < 16; n++) begin
         if (n == 5) begin
            in_valid = 0;
            tick;
         end
         in_valid = 1; in_re = 16'(xr[n]); in_im = 16'(xi[n]);
         tick;
      end
      in_valid = junk;
      in_re = 16'sh7fff;
      in_im = -16'sd1;
   endtask

   task automatic run_frame(input bit const_bins, input bit stall, input bit junk);
      int st = 0;
      starts = 0;
      fft_dones = 0;
      model_frame(const_bins);
      load_samples(junk);
      for (int c = 0; c < 3000 && bin_q.size() > 0; c++) begin
         if (stall && o_valid && o_index == 4'd4 && st < 3) begin
            out_ready = 0;
            st++;
         end else out_ready = 1;
         tick;
      end
      in_valid = 0;
      out_ready = 1;
      check("frame_bins_left", bin_q.size(), 0);
      check("frame_ops_left", op_q.size(), 0);
      check("start_count", starts, 32);
      check("fft_done_count", fft_dones, 1);
      check("valid_drop", o_valid, 0);
      check("ready_back", ready, 1);
      if (stall) check("stall_cycles", st, 3);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog");
      $fatal(1);
   end

   initial begin
      rst = 1;
      tick;
      tick;
      check("rst_ready", ready, 1);
      check("rst_valid", o_valid, 0);
      check("rst_start", bfly_start, 0);
      check("rst_done", fft_done, 0);
      check("rst_data", {in0_re, in0_im, in1_re, in1_im, tw_re_o, tw_im_o}, 0);
      check("rst_out", {o_index, o_re, o_im}, 0);
      rst = 0;
      tick;
      for (int n = 0; n < 16; n++) begin xr[n] = n * 256; xi[n] = 0; end
      run_frame(0, 0, 0);
      check("bitrev_first", first_ops[0], {16'sd0, 16'sd0, 16'sd2048, 16'sd0, 16'sd256, 16'sd0});
      check("bitrev_second", first_ops[1], {16'sd1024, 16'sd0, 16'sd3072, 16'sd0, 16'sd256, 16'sd0});
      extra_done = 1;
      tick;
      extra_done = 0;
      tick;
      check("load_done_ignored", ready, 1);
      for (int n = 0; n < 16; n++) begin
         xr[n] = n == 0 ? 256 : 0; xi[n] = 0; cr[n] = 256; ci[n] = 0;
      end
      run_frame(1, 1, 0);
      hold_len = 5;
      for (int n = 0; n < 16; n++) begin
         xr[n] = 256; xi[n] = 0; cr[n] = n == 0 ? 4096 : 0; ci[n] = 0;
      end
      run_frame(1, 0, 0);
      hold_len = 1;
      for (int n = 0; n < 16; n++) begin xr[n] = n * 256; xi[n] = 0; end
      starts = 0;
      model_frame(0);
      load_samples(0);
      in_valid = 0;
      for (int c = 0; c < 2000 && starts < 17; c++) tick;
      check("mid_starts", starts, 17);
      rst = 1;
      tick;
      check("mid_rst_ready", ready, 1);
      check("mid_rst_valid", o_valid, 0);
      check("mid_rst_start", bfly_start, 0);
      op_q.delete();
      bin_q.delete();
      rst = 0;
      for (int c = 0; c < 10; c++) tick;
      check("mid_rst_stay_load", ready, 1);
      check("mid_rst_no_start", starts, 17);
      for (int n = 0; n < 16; n++) begin
         xr[n] = int'($urandom_range(0, 2000)) - 1000;
         xi[n] = int'($urandom_range(0, 2000)) - 1000;
      end
      run_frame(0, 0, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
